commit_trace_buffer: RTL
========================

# commit_trace_buffer

Parametrised commit-trace capture block for the MIPS core. It samples the core's architectural write events every cycle, the register-file write port and the data-memory write port, together with the PC of the committing instruction. It queues them in program order in a DEPTH-entry FIFO and drains them through a valid/ready stream to a downstream checker or UART dumper. It replaces ad-hoc per-cycle display of the same signals and adds two-event-per-cycle capture, $0 filtering, and overflow accounting.

## Interface
- DEPTH, 16: FIFO entries; power of two, 4..256.
- FILTER_ZERO, 1: 1 = discard register writes with reg_addr == 0.
- DROP_W, 16: width of the saturating dropped-event counter.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- pc  in  32  PC of the instruction committing this cycle.
- reg_we  in  1  register-file write event.
- reg_addr  in  5  destination register.
- reg_data  in  32  value written.
- mem_we  in  1  data-memory write event.
- mem_addr  in  32  byte address written.
- mem_data  in  32  value written.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head.
- out_kind  out  1  0 = register write, 1 = memory write.
- out_pc  out  32  PC of head entry.
- out_addr  out  32  zero-extended reg_addr (kind 0) or mem_addr (kind 1).
- out_data  out  32  written value.
- count  out  log2(DEPTH)+1  occupied entries.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; set on any drop.
- dropped  out  DROP_W  number of events lost, saturating at all-ones.

## Operation
- Event qualification: reg event = reg_we && !(FILTER_ZERO && reg_addr == 0). Mem event = mem_we. Filtered $0 writes count as neither push nor drop.
- Up to two pushes per cycle. When both events occur, the register entry is enqueued before the memory entry. Both carry the same pc.
- Pop = out_valid && out_ready. Free slots for the current cycle = DEPTH − count + pop, so a pop frees its slot for a push in the same cycle.
- Free slots ≥ pushes requested: all events enqueued.
- Free = 1 with two events: the register entry is enqueued, the memory entry is dropped.
- Free = 0: all events are dropped.
- Each dropped event increments dropped by 1 (by 2 if both drop), saturating. Any drop sets overflow, which stays set until reset.
- count_next = count + pushes_accepted − pop. Its range is 0..DEPTH.
- Storage is a circular register array with wr_ptr/rd_ptr of log2(DEPTH) bits, wrapping modulo DEPTH. A two-entry push writes slots wr_ptr and wr_ptr+1 (mod DEPTH).
- out_kind/out_pc/out_addr/out_data present the entry at rd_ptr. They are don't-care when out_valid = 0, but must be stable while out_valid && !out_ready.
- out_valid = (count != 0).
- full = (count == DEPTH).
- Reset values: wr_ptr = rd_ptr = 0, count = 0, out_valid = 0, full = 0, overflow = 0, dropped = 0. Storage contents are not reset.
- Reset asserted mid-stream: all queued entries are discarded. Events presented in a cycle with reset high are ignored.

## Timing
- Capture latency: an event sampled at edge n appears at the head no earlier than after edge n. If the FIFO was empty, out_valid = 1 in cycle n+1. There is no same-cycle bypass.
- Pop takes effect at the edge where out_valid && out_ready. The next entry is presented in the following cycle with no bubble.
- Sustained throughput: 1 pop per cycle. Pushes up to 2 per cycle.
- count, full, overflow and dropped are registered and reflect state after the last edge.
- Ordering: the output order equals capture order. Within a cycle, register precedes memory.

## Test plan
- Reset, then a single event: reg_we = 1, reg_addr = 8, reg_data = 0x1234, pc = 0x3000, out_ready = 0 -> next cycle out_valid = 1, out_kind = 0, out_addr = 8, out_data = 0x1234, out_pc = 0x3000, count = 1. With out_ready = 1 for one cycle -> count = 0, out_valid = 0.
- Filter: FILTER_ZERO = 1, reg_we = 1, reg_addr = 0 -> count stays 0, dropped = 0. With FILTER_ZERO = 0 the same stimulus -> count = 1.
- Dual event: reg (addr 5, 0xAA) and mem (0x4, 0xBB) in the same cycle at pc 0x3010 -> count = 2. Pops yield kind 0 / addr 5, then kind 1 / addr 0x4, both with pc 0x3010.
- Overflow: DEPTH = 4, out_ready = 0, five single reg writes -> full = 1 after the 4th, 5th dropped, overflow = 1, dropped = 1. A dual event at count = 3 -> reg accepted, mem dropped, dropped increments by 1.
- Full with simultaneous pop: count = DEPTH, out_ready = 1, one reg event -> accepted, count stays DEPTH, no drop. Pointers wrap correctly over 3×DEPTH continuous transfers, verified against a reference queue.
- Reset mid-stream: count = 3, overflow = 1, assert reset for one cycle with reg_we = 1 -> count = 0, out_valid = 0, overflow = 0, dropped = 0, and the event is not captured.

Source files
------------

// File: rtl/commit_trace_buffer_if.sv
// Commit-trace bundle: core write events in, trace stream and
// occupancy/overflow status out.
interface commit_trace_buffer_if #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]       pc;
  logic              reg_we;
  logic [4:0]        reg_addr;
  logic [31:0]       reg_data;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_kind;
  logic [31:0]       out_pc;
  logic [31:0]       out_addr;
  logic [31:0]       out_data;
  logic [CW-1:0]     count;
  logic              full;
  logic              overflow;
  logic [DROP_W-1:0] dropped;

  modport master (
    output pc, reg_we, reg_addr, reg_data,
    output mem_we, mem_addr, mem_data,
    output out_ready,
    input  out_valid, out_kind, out_pc,
    input  out_addr, out_data,
    input  count, full, overflow, dropped
  );

  modport slave (
    input  pc, reg_we, reg_addr, reg_data,
    input  mem_we, mem_addr, mem_data,
    input  out_ready,
    output out_valid, out_kind, out_pc,
    output out_addr, out_data,
    output count, full, overflow, dropped
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Captures register/memory commit events in program order into a
// circular FIFO and drains them through a valid/ready stream.
module commit_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter bit FILTER_ZERO = 1'b1,
  parameter int DROP_W      = 16
) (
  input logic             clk,
  input logic             reset,
  commit_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t            store [DEPTH];
  entry_t            reg_entry;
  entry_t            mem_entry;
  entry_t            head;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     free;
  logic [DROP_W-1:0] drops;
  logic              ovf;
  logic              reg_ev;
  logic              mem_ev;
  logic              pop;
  logic              acc_reg;
  logic              acc_mem;
  logic [1:0]        n_req;
  logic [1:0]        n_acc;
  logic [1:0]        n_drop;
  logic [DROP_W:0]   drop_sum;

  assign reg_ev = bus.reg_we &&
                  !(FILTER_ZERO && bus.reg_addr == 5'd0);
  assign mem_ev = bus.mem_we;
  assign pop    = (cnt != '0) && bus.out_ready;

  // A pop this cycle frees its slot for a same-cycle push.
  assign free = CW'(DEPTH) - cnt + CW'(pop);

  // Register event claims the first free slot, memory the next.
  assign acc_reg = reg_ev && (free != '0);
  assign acc_mem = mem_ev && (free > CW'(acc_reg));

  assign n_req  = {1'b0, reg_ev} + {1'b0, mem_ev};
  assign n_acc  = {1'b0, acc_reg} + {1'b0, acc_mem};
  assign n_drop = n_req - n_acc;

  assign drop_sum = {1'b0, drops} + (DROP_W + 1)'(n_drop);

  assign reg_entry = '{
    kind: 1'b0,
    pc:   bus.pc,
    addr: {27'd0, bus.reg_addr},
    data: bus.reg_data
  };
  assign mem_entry = '{
    kind: 1'b1,
    pc:   bus.pc,
    addr: bus.mem_addr,
    data: bus.mem_data
  };

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      drops  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_acc);
      rd_ptr <= rd_ptr + AW'(pop);
      cnt    <= cnt + CW'(n_acc) - CW'(pop);
      if (n_drop != 2'd0) begin
        ovf   <= 1'b1;
        drops <= drop_sum[DROP_W] ? '1
                                  : drop_sum[DROP_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (acc_reg)
        store[wr_ptr] <= reg_entry;
      if (acc_mem)
        store[wr_ptr + AW'(acc_reg)] <= mem_entry;
    end
  end

  assign head = store[rd_ptr];

  assign bus.out_valid = (cnt != '0);
  assign bus.out_kind  = head.kind;
  assign bus.out_pc    = head.pc;
  assign bus.out_addr  = head.addr;
  assign bus.out_data  = head.data;
  assign bus.count     = cnt;
  assign bus.full      = (cnt == CW'(DEPTH));
  assign bus.overflow  = ovf;
  assign bus.dropped   = drops;
endmodule
